// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// The granted owner writes its data slice every cycle it holds the grant.
module rr_reg_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int MAXHOLD = 4
) (
  input  logic                 ck,
  input  logic                 cl,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       d,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         q,
  output logic                 busy
);

  localparam int          OW = $clog2(N);
  localparam int          CW = $clog2(MAXHOLD + 1);
  localparam int unsigned NU = N;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [N-1:0]    gnt_n;
  logic [OW-1:0]   owner_n, ptr, ptr_n, pick, ptr_after;
  logic [W-1:0]    q_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            found;
  int unsigned     idx;
  logic [W-1:0]    d_arr [N];

  always_comb begin
    for (int unsigned i = 0; i < NU; i++) d_arr[i] = d[i*W +: W];
  end

  // Rotating search starting at ptr; index is folded back below N by hand so
  // non-power-of-2 N never selects a nonexistent requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = int'(unsigned'(ptr)) + k;
      if (idx >= NU) idx = idx - NU;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign ptr_after = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
  assign cnt_inc   = (cnt == CW'(MAXHOLD)) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    q_n     = q;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n      = BUSY;
          gnt_n        = '0;
          gnt_n[pick]  = 1'b1;
          owner_n      = pick;
          cnt_n        = '0;
        end
      end
      BUSY: begin
        if (!req[owner]) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = ptr_after;
        end else begin
          q_n   = d_arr[owner];
          cnt_n = cnt_inc;
          // Yield only once the hold budget is spent and someone else is waiting.
          if (cnt_inc == CW'(MAXHOLD) && |(req & ~gnt)) begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = ptr_after;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (cl) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      q     <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      q     <= q_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter (N=4, W=8, MAXHOLD=4).
module tb_rr_reg_arbiter;

  logic        ck = 1'b0;
  logic        cl;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rr_reg_arbiter #(.N(4), .W(8), .MAXHOLD(4)) dut (
    .ck(ck), .cl(cl), .req(req), .d(d),
    .gnt(gnt), .owner(owner), .q(q), .busy(busy)
  );

  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                         input logic [7:0] eq, input logic eb);
    chk({tag, ".gnt"},   32'(gnt),   32'(eg));
    chk({tag, ".owner"}, 32'(owner), 32'(eo));
    chk({tag, ".q"},     32'(q),     32'(eq));
    chk({tag, ".busy"},  32'(busy),  32'(eb));
  endtask

  task automatic set_d(input int i, input logic [7:0] v);
    d[i*8 +: 8] = v;
  endtask

  initial begin
    logic [1:0] o;
    logic [3:0] oh;
    cl  = 1'b1;
    req = '0;
    d   = '0;

    // 1. reset and idle
    step(); step();
    chk_all("rst", 4'b0000, 2'd0, 8'h00, 1'b0);
    cl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("idle", 4'b0000, 2'd0, 8'h00, 1'b0);
    end

    // 2. single requester, latency and release
    req = 4'b0001; set_d(0, 8'h11);
    step(); chk_all("t2.grant", 4'b0001, 2'd0, 8'h00, 1'b1);
    step(); chk_all("t2.w1",    4'b0001, 2'd0, 8'h11, 1'b1);
    set_d(0, 8'h22);
    step(); chk_all("t2.w2",    4'b0001, 2'd0, 8'h22, 1'b1);
    req = 4'b0000;
    step(); chk_all("t2.rel",   4'b0000, 2'd0, 8'h22, 1'b0);

    // 3. two requesters, MAXHOLD hand-off (reset first so ptr=0)
    cl = 1'b1; step(); cl = 1'b0;
    chk_all("t3.rst", 4'b0000, 2'd0, 8'h00, 1'b0);
    req = 4'b0011; set_d(0, 8'hA0); set_d(1, 8'hB1);
    step(); chk_all("t3.grant", 4'b0001, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("t3.hold", 4'b0001, 2'd0, 8'hA0, 1'b1);
    end
    step(); chk_all("t3.yield", 4'b0000, 2'd0, 8'hA0, 1'b0);
    step(); chk_all("t3.g1",    4'b0010, 2'd1, 8'hA0, 1'b1);
    step(); chk_all("t3.w1",    4'b0010, 2'd1, 8'hB1, 1'b1);
    req = 4'b0000;
    step(); chk_all("t3.rel",   4'b0000, 2'd1, 8'hB1, 1'b0);

    // 4. all requesting: order 0,1,2,3,0 with wrap
    cl = 1'b1; step(); cl = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_d(i, 8'h40 + 8'(i));
    for (int g = 0; g < 5; g++) begin
      o  = 2'(g % 4);
      oh = 4'b0001 << o;
      step(); chk("t4.grant.gnt", 32'(gnt), 32'(oh));
      chk("t4.grant.owner", 32'(owner), 32'(o));
      for (int w = 0; w < 3; w++) begin
        step(); chk("t4.hold.gnt", 32'(gnt), 32'(oh));
        chk("t4.hold.q", 32'(q), 32'(8'h40 + 8'(o)));
      end
      step(); chk_all("t4.yield", 4'b0000, o, 8'h40 + 8'(o), 1'b0);
    end
    req = 4'b0000;
    step(); chk_all("t4.idle", 4'b0000, 2'd0, 8'h40, 1'b0);

    // 5. lone requester holds past MAXHOLD, yields at once when contended
    req = 4'b0100;
    step(); chk_all("t5.grant", 4'b0100, 2'd2, 8'h40, 1'b1);
    for (int w = 0; w < 9; w++) begin
      set_d(2, 8'h60 + 8'(w));
      step(); chk_all("t5.hold", 4'b0100, 2'd2, 8'h60 + 8'(w), 1'b1);
    end
    req = 4'b0110; set_d(2, 8'h7E);
    step(); chk_all("t5.yield", 4'b0000, 2'd2, 8'h7E, 1'b0);
    step(); chk_all("t5.g1",    4'b0010, 2'd1, 8'h7E, 1'b1);

    // 6. reset mid-grant while owner 2 is writing
    req = 4'b0000;
    step(); chk_all("t6.rel", 4'b0000, 2'd1, 8'h7E, 1'b0);
    req = 4'b0100; set_d(2, 8'h5C);
    step(); chk_all("t6.g2", 4'b0100, 2'd2, 8'h7E, 1'b1);
    step(); chk_all("t6.w",  4'b0100, 2'd2, 8'h5C, 1'b1);
    cl = 1'b1;
    step(); chk_all("t6.rst", 4'b0000, 2'd0, 8'h00, 1'b0);
    cl = 1'b0; req = 4'b0110;
    step(); chk_all("t6.g1", 4'b0010, 2'd1, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
